// File: rtl/onehot_enc_pkg.sv
// Shared types and sizing for the one-hot/multi-hot to binary index encoder.
package onehot_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int N_DEFAULT  = 8;
  localparam int IW_DEFAULT = $clog2(N_DEFAULT);

endpackage

// File: rtl/lsb_index_finder.sv
// Combinational search for the lowest set bit of a vector, plus single/any-set flags.
module lsb_index_finder
  import onehot_enc_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending_i,
  output logic [IW-1:0] index_o,
  output logic          is_single_o,
  output logic          any_set_o
);

  // Scan from the top down so the last hit, the lowest set bit, wins.
  always_comb begin
    index_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_i[i]) index_o = IW'(i);
    end
  end

  assign any_set_o   = |pending_i;
  assign is_single_o = any_set_o && ((pending_i & (pending_i - N'(1))) == '0);

endmodule

// File: rtl/onehot_encoder_8to3.sv
// Accepts a request vector and emits the index of each set bit, lowest first, one beat per handshake.
module onehot_encoder_8to3
  import onehot_enc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out,
  output logic          out_last,
  output logic          out_multi,
  output logic          zero_drop
);

  state_e         state_q;
  logic [N-1:0]   pending_q;
  logic [N-1:0]   pending_d;
  logic           multi_q;
  logic           zeroDrop_q;
  logic [IW-1:0]  lowIndex;
  logic           isSingle;
  logic           anySet;
  logic           inIsMulti;

  lsb_index_finder #(
    .N  (N),
    .IW (IW)
  ) u_finder (
    .pending_i   (pending_q),
    .index_o     (lowIndex),
    .is_single_o (isSingle),
    .any_set_o   (anySet)
  );

  assign pending_d = pending_q & (pending_q - N'(1));
  assign inIsMulti = (in & (in - N'(1))) != '0;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT) && anySet;
  assign out       = lowIndex;
  assign out_last  = out_valid && isSingle;
  assign out_multi = multi_q;
  assign zero_drop = zeroDrop_q;

  // An empty pending register in EMIT cannot happen in protocol; fall back to IDLE if it does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      multi_q    <= 1'b0;
      zeroDrop_q <= 1'b0;
    end else begin
      zeroDrop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in != '0) begin
              pending_q <= in;
              multi_q   <= inIsMulti;
              state_q   <= EMIT;
            end else begin
              zeroDrop_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (!anySet) begin
            state_q   <= IDLE;
            pending_q <= '0;
            multi_q   <= 1'b0;
          end else if (out_ready) begin
            if (isSingle) begin
              state_q   <= IDLE;
              pending_q <= '0;
              multi_q   <= 1'b0;
            end else begin
              pending_q <= pending_d;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= '0;
          multi_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_encoder_8to3.sv
// Directed-vector bench for onehot_encoder_8to3 with hand-computed expected beats.
module tb_onehot_encoder_8to3;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out;
  logic       out_last;
  logic       out_multi;
  logic       zero_drop;

  int vectorCount = 0;
  int errCount    = 0;

  onehot_encoder_8to3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_last  (out_last),
    .out_multi (out_multi),
    .zero_drop (zero_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the summary counts stay honest.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one vector for a single cycle; returns in the cycle after acceptance.
  task automatic applyStimulus(input logic [7:0] vec);
    in_valid = 1'b1;
    in       = vec;
    step();
    in_valid = 1'b0;
    in       = 8'h00;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"},  int'(in_ready),  1);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
  endtask

  int multiExp [4] = '{0, 2, 5, 7};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in        = 8'h00;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Asynchronous reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_in_ready",  int'(in_ready),  1);
    checkOutput("rst_zero_drop", int'(zero_drop), 0);
    checkOutput("rst_out",       int'(out),       0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("idle_out_valid", int'(out_valid), 0);
      checkOutput("idle_in_ready",  int'(in_ready),  1);
      checkOutput("idle_zero_drop", int'(zero_drop), 0);
      checkOutput("idle_out",       int'(out),       0);
    end

    // One-hot vector
    applyStimulus(8'b0001_0000);
    checkOutput("oh_valid",    int'(out_valid), 1);
    checkOutput("oh_out",      int'(out),       4);
    checkOutput("oh_last",     int'(out_last),  1);
    checkOutput("oh_multi",    int'(out_multi), 0);
    checkOutput("oh_in_ready", int'(in_ready),  0);
    step();
    checkIdle("oh_done");

    // Multi-hot vector
    applyStimulus(8'b1010_0101);
    for (int k = 0; k < 4; k++) begin
      checkOutput("mh_valid",    int'(out_valid), 1);
      checkOutput("mh_out",      int'(out),       multiExp[k]);
      checkOutput("mh_multi",    int'(out_multi), 1);
      checkOutput("mh_last",     int'(out_last),  (k == 3) ? 1 : 0);
      checkOutput("mh_in_ready", int'(in_ready),  0);
      step();
    end
    checkIdle("mh_done");

    // Backpressure: three stalled cycles, then accept
    out_ready = 1'b0;
    applyStimulus(8'b1100_0000);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 1'b1;
      checkOutput("bp_valid", int'(out_valid), 1);
      checkOutput("bp_out",   int'(out),       6);
      checkOutput("bp_last",  int'(out_last),  0);
      checkOutput("bp_multi", int'(out_multi), 1);
      step();
    end
    checkOutput("bp2_valid", int'(out_valid), 1);
    checkOutput("bp2_out",   int'(out),       7);
    checkOutput("bp2_last",  int'(out_last),  1);
    step();
    checkIdle("bp_done");

    // All-zero vector is dropped with a single pulse
    applyStimulus(8'h00);
    checkOutput("zd_pulse",    int'(zero_drop), 1);
    checkOutput("zd_valid",    int'(out_valid), 0);
    checkOutput("zd_in_ready", int'(in_ready),  1);
    step();
    checkOutput("zd_pulse_end", int'(zero_drop), 0);
    checkOutput("zd_valid2",    int'(out_valid), 0);

    // New input during EMIT must be ignored
    applyStimulus(8'h03);
    in_valid = 1'b1;
    in       = 8'hFF;
    checkOutput("ign_out0",   int'(out),       0);
    checkOutput("ign_multi",  int'(out_multi), 1);
    checkOutput("ign_last0",  int'(out_last),  0);
    step();
    checkOutput("ign_valid1", int'(out_valid), 1);
    checkOutput("ign_out1",   int'(out),       1);
    checkOutput("ign_last1",  int'(out_last),  1);
    in_valid = 1'b0;
    in       = 8'h00;
    step();
    checkIdle("ign_done");
    step();
    checkOutput("ign_not_captured", int'(out_valid), 0);

    // Reset during emission aborts the vector
    applyStimulus(8'hF0);
    checkOutput("rm_out0", int'(out), 4);
    step();
    checkOutput("rm_out1", int'(out), 5);
    #3 rst = 1'b1;
    #1;
    checkOutput("rm_valid",    int'(out_valid), 0);
    checkOutput("rm_in_ready", int'(in_ready),  1);
    checkOutput("rm_out",      int'(out),       0);
    checkOutput("rm_multi",    int'(out_multi), 0);
    step();
    rst = 1'b0;
    step();
    checkIdle("rm_after");
    applyStimulus(8'h01);
    checkOutput("rm_new_valid", int'(out_valid), 1);
    checkOutput("rm_new_out",   int'(out),       0);
    checkOutput("rm_new_last",  int'(out_last),  1);
    checkOutput("rm_new_multi", int'(out_multi), 0);
    step();
    checkIdle("rm_new_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errCount);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_8to3.md
Name: onehot_encoder_8to3

Overview:
- Sequential inverse of the team's combinational 3-to-8 decoder.
- Accepts an 8-bit request vector through a valid/ready handshake and emits the 3-bit index of each set bit, lowest index first, one beat per accepted output handshake.
- Sits upstream of decoder-driven select logic: it turns one-hot or multi-hot request lines back into binary codes for transport or arbitration.

Parameters:
- N, 8, input vector width; must be a power of two and at least 2.
- IW, $clog2(N) = 3, output index width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request vector present on in
- in_ready  output  1  block can accept a vector (high only in IDLE)
- in  input  N  request vector; bit i set means index i is requested
- out_valid  output  1  index on out is valid
- out_ready  input  1  downstream accepts the current index
- out  output  IW  binary index of the lowest pending set bit
- out_last  output  1  current beat is the final index of this vector
- out_multi  output  1  the originating vector had more than one bit set
- zero_drop  output  1  one-cycle pulse: an all-zero vector was accepted and discarded

Behaviour:
- Reset, asynchronous, active-high:
  - state = IDLE, pending = 0, multi_r = 0.
  - Outputs: out_valid=0, out=0, out_last=0, out_multi=0, zero_drop=0, in_ready=1.
  - Reset asserted mid-emission aborts at once: out_valid drops in the same cycle and no further beats of that vector are emitted.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in!=0: pending <= in; multi_r <= (popcount(in)>1); go to EMIT.
  - On in_valid && in==0: stay in IDLE; zero_drop=1 in the next cycle only (registered pulse).
- EMIT:
  - in_ready=0; in_valid is ignored and nothing is captured.
  - out_valid=1, combinational from the pending register.
  - out = index of the lowest set bit of pending.
  - out_last = (pending has exactly one bit set).
  - out_multi = multi_r, held constant for every beat of the vector.
  - On out_valid && out_ready: clear the lowest set bit of pending. If out_last, go to IDLE with pending = 0 and multi_r = 0.
  - With out_ready low, out, out_last and out_multi stay stable and out_valid stays high. No beat is dropped or repeated.
- Latency and throughput:
  - A vector accepted in cycle T gives out_valid=1 in cycle T+1.
  - Emission takes popcount(in) handshake cycles when out_ready is held high.
  - in_ready returns high in the cycle after the last beat's handshake. There is no same-cycle bypass, so back-to-back vectors see a minimum 1-cycle gap.
- Index encoding: bit i maps to out=i, which is exactly the inverse of the decoder's one-hot mapping. MSB index is N-1 = 7.
- Out-of-protocol case: pending cannot be zero in EMIT. If an implementation reaches that state, it returns to IDLE with out_valid=0.

Decomposition:
- Package onehot_enc_pkg holds:
  - state enum {IDLE, EMIT}
  - N_DEFAULT=8
  - IW derivation
- One sub-module is natural: lsb_index_finder, a combinational block that takes pending[N-1:0] and produces index[IW-1:0], is_single and any_set.
- Popcount>1 detection is done as (v & (v-1)) != 0 inside the top level. No full adder tree.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> out_valid=0, in_ready=1, zero_drop=0, out=0 immediately; release and idle for 5 cycles -> outputs unchanged.
- One-hot: in=8'b0001_0000, in_valid for 1 cycle, out_ready=1 -> next cycle out=4, out_last=1, out_multi=0; the cycle after that in_ready=1 and out_valid=0.
- Multi-hot: in=8'b1010_0101, out_ready=1 -> four consecutive beats out=0,2,5,7.
  - out_multi=1 on all four beats.
  - out_last=1 only on out=7.
  - in_ready stays low until the cycle after the beat with out=7.
- Backpressure: in=8'b1100_0000, out_ready=0 for 3 cycles then 1 -> out=6 held stable 4 cycles with out_valid high, then out=7 with out_last=1, then IDLE.
- Zero vector plus ignored input: in=8'h00 accepted -> zero_drop=1 for exactly 1 cycle and no out_valid. During EMIT of in=8'h03, drive in_valid=1 with in=8'hFF -> it is not captured, only indices 0 and 1 are emitted.
- Reset mid-emission: in=8'hF0, assert rst after the first beat (out=4) -> out_valid=0 at once. After release, in=8'h01 -> single beat out=0 with out_multi=0.
